ulpi_reg_reader: RTL and testbench



---
 rtl/ulpi_pkg.sv | 20 ++
 rtl/ulpi_data_iobuf.sv | 19 +
 rtl/ulpi_reg_reader.sv | 111 +++++++++++
 tb/tb_ulpi_reg_reader.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ulpi_pkg.sv
// Shared ULPI constants and the register-reader state encoding.
package ulpi_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    localparam logic [1:0] ULPI_CMD_NOOP  = 2'b00;
    localparam logic [1:0] ULPI_CMD_REGWR = 2'b10;
    localparam logic [1:0] ULPI_CMD_REGRD = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TXCMD   = 3'd1,
        TURN    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4,
        ABORT   = 3'd5
    } ulpi_state_t;

endpackage

// File: rtl/ulpi_data_iobuf.sv
// 8-bit ULPI data pad: link drives only while it wants the bus and the PHY does not.
module ulpi_data_iobuf
    import ulpi_pkg::*;
(
    input  logic              drive,
    input  logic              dir,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    inout  wire  [DATA_W-1:0] pad
);

    logic oe;

    // Combinational so the link lets go in the very cycle dir rises.
    assign oe      = drive & ~dir;
    assign pad     = oe ? tx_data : {DATA_W{1'bz}};
    assign rx_data = pad;

endmodule

// File: rtl/ulpi_reg_reader.sv
// ULPI RegRead engine: TX CMD, turnaround, capture, hand back with data_ready.
// Define ULPI_REG_READER_SVA_EN to compile the protocol assertions.
//
// state   | meaning
// IDLE    | bus idle, waiting for en with dir low
// TXCMD   | driving {REGRD, addr}, waiting for nxt
// TURN    | bus released, waiting for PHY to take dir
// CAPTURE | PHY owns bus, latch first non-nxt byte
// DONE    | data_ready high until en drops
// ABORT   | PHY pre-empted the TX CMD, wait for dir low then retry
module ulpi_reg_reader
    import ulpi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    input  logic              ulpi_dir,
    input  logic              ulpi_nxt,
    inout  wire  [DATA_W-1:0] ulpi_data,
    output logic              ulpi_stp,
    output logic [DATA_W-1:0] data,
    output logic              data_ready
);

    ulpi_state_t       state;
    logic              drive_q;
    logic [DATA_W-1:0] tx_byte;
    logic [DATA_W-1:0] rx_byte;

    // addr is looked at every TXCMD cycle rather than being latched once.
    assign tx_byte  = (state == TXCMD) ? {ULPI_CMD_REGRD, addr}
                                       : {ULPI_CMD_NOOP, {ADDR_W{1'b0}}};
    assign ulpi_stp = 1'b0;

    ulpi_data_iobuf u_iobuf (
        .drive   (drive_q),
        .dir     (ulpi_dir),
        .tx_data (tx_byte),
        .rx_data (rx_byte),
        .pad     (ulpi_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            drive_q    <= 1'b0;
            data       <= '0;
            data_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && !ulpi_dir) begin
                        state   <= TXCMD;
                        drive_q <= 1'b1;
                    end
                end
                TXCMD: begin
                    // A PHY turnaround wins over a same-cycle nxt.
                    if (ulpi_dir) begin
                        state   <= ABORT;
                        drive_q <= 1'b0;
                    end else if (ulpi_nxt) begin
                        state   <= TURN;
                        drive_q <= 1'b0;
                    end
                end
                ABORT: begin
                    if (!ulpi_dir) begin
                        state   <= TXCMD;
                        drive_q <= 1'b1;
                    end
                end
                TURN: begin
                    if (ulpi_dir) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (!ulpi_dir) begin
                        state   <= TXCMD;
                        drive_q <= 1'b1;
                    end else if (!ulpi_nxt) begin
                        state      <= DONE;
                        data       <= rx_byte;
                        data_ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (!en) begin
                        state      <= IDLE;
                        data_ready <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ULPI_REG_READER_SVA_EN
    a_no_drive_on_dir: assert property (@(posedge clk) ulpi_dir |-> !u_iobuf.oe);
    a_stp_low:         assert property (@(posedge clk) ulpi_stp == 1'b0);
    a_addr_stable:     assert property (@(posedge clk) disable iff (!rst_n)
                           (en && $past(en) && state != DONE) |-> $stable(addr));
    a_ready_in_done:   assert property (@(posedge clk) data_ready |-> state == DONE);
`endif

endmodule

// File: tb/tb_ulpi_reg_reader.sv
// Directed bench for ulpi_reg_reader with a cycle-scripted PHY model.
module tb_ulpi_reg_reader;
    import ulpi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  addr;
    logic        en;
    logic        ulpi_dir;
    logic        ulpi_nxt;
    wire  [7:0]  ulpi_data;
    logic        ulpi_stp;
    logic [7:0]  data;
    logic        data_ready;

    logic        phy_oe;
    logic [7:0]  phy_byte;

    int checks   = 0;
    int failures = 0;

    assign ulpi_data = phy_oe ? phy_byte : 8'hzz;

    always #5 clk = ~clk;

    ulpi_reg_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .en         (en),
        .ulpi_dir   (ulpi_dir),
        .ulpi_nxt   (ulpi_nxt),
        .ulpi_data  (ulpi_data),
        .ulpi_stp   (ulpi_stp),
        .data       (data),
        .data_ready (data_ready)
    );

    typedef struct {
        logic [5:0] addr;
        logic [7:0] rd_val;
        int         nxt_delay;
        int         hold;
        logic [7:0] exp_cmd;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    // Returns 2 time units after the edge; inputs are set here, outputs sampled 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic run_read(input vec_t v, input int idx);
        addr = v.addr; en = 1'b1; ulpi_dir = 1'b0; ulpi_nxt = 1'b0; phy_oe = 1'b0;
        #1;
        chk("idle_release", idx, 32'(dut.u_iobuf.oe), 32'd0);
        next_cycle();
        for (int i = 0; i <= v.nxt_delay; i++) begin
            ulpi_nxt = (i == v.nxt_delay);
            #1;
            chk("txcmd_oe", idx, 32'(dut.u_iobuf.oe), 32'd1);
            chk("txcmd_bus", idx, 32'(ulpi_data), 32'(v.exp_cmd));
            next_cycle();
        end
        ulpi_nxt = 1'b0; ulpi_dir = 1'b1;
        #1;
        chk("turn_release", idx, 32'(dut.u_iobuf.oe), 32'd0);
        next_cycle();
        phy_oe = 1'b1; phy_byte = v.rd_val;
        #1;
        chk("early_ready", idx, 32'(data_ready), 32'd0);
        next_cycle();
        ulpi_dir = 1'b0; phy_oe = 1'b0;
        #1;
        chk("data", idx, 32'(data), 32'(v.exp_data));
        chk("ready", idx, 32'(data_ready), 32'd1);
        for (int h = 0; h < v.hold; h++) begin
            next_cycle();
            #1;
            chk("hold_ready", idx, 32'(data_ready), 32'd1);
            chk("hold_no_tx", idx, 32'(dut.u_iobuf.oe), 32'd0);
        end
        en = 1'b0;
        #1;
        chk("ready_en_low", idx, 32'(data_ready), 32'd1);
        next_cycle();
        #1;
        chk("ready_fall", idx, 32'(data_ready), 32'd0);
        chk("after_no_tx", idx, 32'(dut.u_iobuf.oe), 32'd0);
        chk("data_hold", idx, 32'(data), 32'(v.exp_data));
    endtask

    initial begin
        vecs[0] = '{6'h00, 8'h24, 0, 0, 8'hC0, 8'h24};
        vecs[1] = '{6'h01, 8'h04, 0, 0, 8'hC1, 8'h04};
        vecs[2] = '{6'h02, 8'h09, 0, 0, 8'hC2, 8'h09};
        vecs[3] = '{6'h03, 8'h00, 0, 0, 8'hC3, 8'h00};
        vecs[4] = '{6'h2A, 8'hA5, 5, 0, 8'hEA, 8'hA5};
        vecs[5] = '{6'h3F, 8'h5C, 0, 4, 8'hFF, 8'h5C};

        rst_n = 1'b0; en = 1'b0; addr = '0; ulpi_dir = 1'b0; ulpi_nxt = 1'b0;
        phy_oe = 1'b0; phy_byte = '0;
        next_cycle();
        next_cycle();
        #1;
        chk("rst_data", 0, 32'(data), 32'h00);
        chk("rst_ready", 0, 32'(data_ready), 32'd0);
        chk("rst_oe", 0, 32'(dut.u_iobuf.oe), 32'd0);
        chk("rst_stp", 0, 32'(ulpi_stp), 32'd0);
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 6; i++) begin
            run_read(vecs[i], i);
        end

        // PHY pre-empts the TX CMD with dir for 3 cycles, then lets the retry through.
        addr = 6'h00; en = 1'b1;
        next_cycle();
        #1;
        chk("abort_tx_bus", 0, 32'(ulpi_data), 32'hC0);
        ulpi_dir = 1'b1; phy_oe = 1'b1; phy_byte = 8'h5A;
        #1;
        chk("abort_same_cycle_release", 0, 32'(dut.u_iobuf.oe), 32'd0);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            #1;
            chk("abort_held_release", i, 32'(dut.u_iobuf.oe), 32'd0);
        end
        next_cycle();
        ulpi_dir = 1'b0; phy_oe = 1'b0;
        #1;
        chk("abort_dir_fall_release", 0, 32'(dut.u_iobuf.oe), 32'd0);
        next_cycle();
        ulpi_nxt = 1'b1;
        #1;
        chk("abort_retry_bus", 0, 32'(ulpi_data), 32'hC0);
        next_cycle();
        ulpi_nxt = 1'b0; ulpi_dir = 1'b1;
        next_cycle();
        phy_oe = 1'b1; phy_byte = 8'h77;
        next_cycle();
        ulpi_dir = 1'b0; phy_oe = 1'b0;
        #1;
        chk("abort_data", 0, 32'(data), 32'h77);
        chk("abort_ready", 0, 32'(data_ready), 32'd1);
        en = 1'b0;
        next_cycle();
        next_cycle();

        // Reset lands while waiting in TURN.
        addr = 6'h05; en = 1'b1;
        next_cycle();
        ulpi_nxt = 1'b1;
        next_cycle();
        ulpi_nxt = 1'b0;
        #1;
        chk("pre_rst_turn", 0, 32'(dut.state), 32'(TURN));
        rst_n = 1'b0; en = 1'b0;
        next_cycle();
        #1;
        chk("midrst_state", 0, 32'(dut.state), 32'(IDLE));
        chk("midrst_ready", 0, 32'(data_ready), 32'd0);
        chk("midrst_oe", 0, 32'(dut.u_iobuf.oe), 32'd0);
        chk("midrst_data", 0, 32'(data), 32'h00);
        rst_n = 1'b1;
        next_cycle();
        #1;
        chk("post_rst_idle", 0, 32'(dut.state), 32'(IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
